mul_arbiter: RTL and testbench

- Shares one iterative shift-add 32x32->64 multiplier between NREQ requesters, e.g. two issue ports.
- Arbitrates requests round-robin and forwards operands over the multiplier's in_valid/in_ready handshake.
- Records which requester owns the in-flight operation, and routes the multiplier's one-cycle out_valid pulse into that requester's result buffer.
- Each requester drains its own buffer through a valid/ready response handshake.
- Sits between the execute-stage issue logic and the multiplier.

---
 rtl/mul_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/mul_arbiter.sv | 148 ++++++++++++++
 tb/tb_mul_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared constants, FSM state type and index-width helper for the multiplier arbiter
package mul_pkg;

    localparam int MUL_W  = 32;
    localparam int PROD_W = 64;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Bits needed to index n items; never less than 1 so a 1-bit index still exists.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin priority picker with pointer input and one-hot/index grant
//
// Ports:
//   req_i        N-bit request mask
//   ptr_i        index with highest priority this cycle
//   gnt_valid_o  at least one request present
//   gnt_idx_o    granted index (equals ptr_i when nothing is granted)
//   gnt_onehot_o one-hot grant, all zero when nothing is granted
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          gnt_valid_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic [N-1:0]  gnt_onehot_o
);

    function automatic int wrap_idx(input int p, input int k);
        return (p + k) % N;
    endfunction

    // Scan from the farthest offset down to the pointer itself; the last hit
    // written is the nearest one at or after the pointer.
    always_comb begin
        gnt_valid_o  = 1'b0;
        gnt_idx_o    = ptr_i;
        gnt_onehot_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[wrap_idx(int'(ptr_i), k)]) begin
                gnt_valid_o  = 1'b1;
                gnt_idx_o    = IW'(wrap_idx(int'(ptr_i), k));
                gnt_onehot_o = N'(1) << wrap_idx(int'(ptr_i), k);
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - shares one iterative multiplier between NREQ requesters with per-requester result buffers
//
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   req_valid/req_ready            per-requester issue handshake
//   req_src1/req_src2              packed operands, requester i at [32i+:32]
//   rsp_valid/rsp_ready/rsp_result per-requester result buffer drain, result packed at [64i+:64]
//   mul_in_valid/mul_in_ready      operand handshake to the multiplier
//   mul_src1/mul_src2              operands to the multiplier
//   mul_out_valid/mul_result       one-cycle done pulse and product from the multiplier
//   busy                           an operation is in flight
//   err                            sticky watchdog timeout
module mul_arbiter
    import mul_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int TMO_CYCLES = 40
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*MUL_W-1:0]   req_src1,
    input  logic [NREQ*MUL_W-1:0]   req_src2,
    output logic [NREQ-1:0]         rsp_valid,
    input  logic [NREQ-1:0]         rsp_ready,
    output logic [NREQ*PROD_W-1:0]  rsp_result,
    output logic                    mul_in_valid,
    input  logic                    mul_in_ready,
    output logic [MUL_W-1:0]        mul_src1,
    output logic [MUL_W-1:0]        mul_src2,
    input  logic                    mul_out_valid,
    input  logic [PROD_W-1:0]       mul_result,
    output logic                    busy,
    output logic                    err
);

    localparam int IW = clog2(NREQ);
    localparam int WW = clog2(TMO_CYCLES + 1);

    state_t            state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]   slot_valid_q, slot_valid_d;
    logic [PROD_W-1:0] slot_q [NREQ];
    logic              err_q, err_d;
    logic [WW-1:0]     wdog_q, wdog_d;

    logic [NREQ-1:0]   eligible;
    logic              gnt_valid;
    logic [IW-1:0]     gnt_idx;
    logic [NREQ-1:0]   gnt_onehot;
    logic              issue;

    // A full slot blocks its owner: the multiplier's done pulse cannot be stalled.
    assign eligible = req_valid & ~slot_valid_q;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr (
        .req_i        (eligible),
        .ptr_i        (rr_ptr_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_idx_o    (gnt_idx),
        .gnt_onehot_o (gnt_onehot)
    );

    // Issue is held off while reset is asserted so every handshake output is low.
    assign issue = resetn && (state_q == IDLE) && gnt_valid;

    // gnt_idx falls back to rr_ptr when nothing is granted, so the operand
    // outputs then carry that requester's (don't-care) operands.
    assign mul_src1 = req_src1[int'(gnt_idx)*MUL_W +: MUL_W];
    assign mul_src2 = req_src2[int'(gnt_idx)*MUL_W +: MUL_W];

    assign rsp_valid = slot_valid_q;
    assign err       = err_q;

    for (genvar i = 0; i < NREQ; i++) begin : g_rsp
        assign rsp_result[i*PROD_W +: PROD_W] = slot_q[i];
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        wdog_d       = wdog_q;
        err_d        = err_q;
        slot_valid_d = slot_valid_q & ~(slot_valid_q & rsp_ready);
        mul_in_valid = 1'b0;
        req_ready    = '0;
        busy         = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    mul_in_valid = 1'b1;
                    req_ready    = gnt_onehot & {NREQ{mul_in_ready}};
                    if (mul_in_ready) begin
                        state_d  = BUSY;
                        owner_d  = gnt_idx;
                        rr_ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
                        wdog_d   = '0;
                    end
                end
            end
            BUSY: begin
                busy   = 1'b1;
                wdog_d = wdog_q + WW'(1);
                if (mul_out_valid) begin
                    // Capture is applied after the drain clear, so it wins.
                    slot_valid_d[owner_q] = 1'b1;
                    state_d               = IDLE;
                end else if (wdog_q == WW'(TMO_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            slot_valid_q <= '0;
            err_q        <= 1'b0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            slot_valid_q <= slot_valid_d;
            err_q        <= err_d;
            wdog_q       <= wdog_d;
        end
    end

    // Result data is qualified by slot_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state_q == BUSY && mul_out_valid) begin
            slot_q[owner_q] <= mul_result;
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - scoreboard bench for mul_arbiter with a behavioural multiplier
module tb_mul_arbiter;
    import mul_pkg::*;

    localparam int NREQ = 2;
    localparam int TMO  = 40;

    logic                   clk = 1'b0;
    logic                   resetn = 1'b0;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*32-1:0]     req_src1 = '0;
    logic [NREQ*32-1:0]     req_src2 = '0;
    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ-1:0]        rsp_ready = '0;
    logic [NREQ*64-1:0]     rsp_result;
    logic                   mul_in_valid;
    logic                   mul_in_ready = 1'b0;
    logic [31:0]            mul_src1;
    logic [31:0]            mul_src2;
    logic                   mul_out_valid = 1'b0;
    logic [63:0]            mul_result = '0;
    logic                   busy;
    logic                   err;

    always #5 clk = ~clk;

    mul_arbiter #(.NREQ(NREQ), .TMO_CYCLES(TMO)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_src1      (req_src1),
        .req_src2      (req_src2),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .mul_in_valid  (mul_in_valid),
        .mul_in_ready  (mul_in_ready),
        .mul_src1      (mul_src1),
        .mul_src2      (mul_src2),
        .mul_out_valid (mul_out_valid),
        .mul_result    (mul_result),
        .busy          (busy),
        .err           (err)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q [NREQ][$];

    // behavioural multiplier controls
    logic        mul_auto = 1'b1;
    logic        lat_rand = 1'b0;
    int          lat_cfg  = 2;
    int          inj_cnt  = 0;
    int          inj_seen = 0;
    logic [63:0] inj_val  = '0;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [63:0] prod = '0;
    logic [NREQ-1:0] acc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_src1[32*i +: 32] = a;
        req_src2[32*i +: 32] = b;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_rsp(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid[i] && n < 100);
        chk($sformatf("rsp_valid%0d_arrives", i), 64'(rsp_valid[i]), 64'd1);
    endtask

    task automatic wait_acc(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req_valid[i] && req_ready[i]) && n < 100);
        chk($sformatf("req%0d_accepted", i), 64'(req_ready[i]), 64'd1);
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        wait_rsp(i);
        tick();
        rsp_ready[i] = 1'b1;
        tick();
        rsp_ready[i] = 1'b0;
        chk($sformatf("rsp_valid%0d_cleared", i), 64'(rsp_valid[i]), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        resetn    = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        for (int i = 0; i < NREQ; i++) exp_q[i].delete();
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        fork
            // monitor: record accepted requests, compare drained results
            forever begin
                @(negedge clk);
                for (int i = 0; i < NREQ; i++) begin
                    if (resetn && req_valid[i] && req_ready[i])
                        exp_q[i].push_back(64'(req_src1[32*i +: 32]) * 64'(req_src2[32*i +: 32]));
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (resetn && rsp_valid[i] && rsp_ready[i]) begin
                        if (exp_q[i].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rsp%0d_unexpected: got %0h expected no response", i, rsp_result[64*i +: 64]);
                        end else begin
                            chk($sformatf("rsp%0d_result", i), rsp_result[64*i +: 64], exp_q[i].pop_front());
                        end
                    end
                end
            end
            // behavioural multiplier
            forever begin
                @(negedge clk);
                if (resetn && mul_auto && mul_in_valid && mul_in_ready) begin
                    pend = 1'b1;
                    cnt  = lat_rand ? int'($urandom_range(0, 5)) : lat_cfg;
                    prod = 64'(mul_src1) * 64'(mul_src2);
                end
                @(posedge clk);
                #1;
                mul_out_valid = 1'b0;
                if (inj_cnt != inj_seen) begin
                    inj_seen      = inj_cnt;
                    mul_out_valid = 1'b1;
                    mul_result    = inj_val;
                end else if (pend) begin
                    if (cnt == 0) begin
                        mul_out_valid = 1'b1;
                        mul_result    = prod;
                        pend          = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
            // stimulus
            begin
                req_valid    = '1;
                mul_in_ready = 1'b1;
                #12;
                chk("rst_req_ready", 64'(req_ready), 64'd0);
                chk("rst_mul_in_valid", 64'(mul_in_valid), 64'd0);
                chk("rst_busy0", 64'(busy), 64'd0);
                chk("rst_err0", 64'(err), 64'd0);
                chk("rst_rsp0", 64'(rsp_valid), 64'd0);
                req_valid = '0;
                tick();
                resetn = 1'b1;

                // single request
                lat_cfg = 2;
                set_req(0, 32'd3, 32'd5);
                @(negedge clk);
                chk("single_in_valid", 64'(mul_in_valid), 64'd1);
                chk("single_req_ready", 64'(req_ready), 64'b01);
                chk("single_src1", 64'(mul_src1), 64'd3);
                chk("single_src2", 64'(mul_src2), 64'd5);
                tick();
                req_valid[0] = 1'b0;
                chk("single_busy", 64'(busy), 64'd1);
                chk("single_busy_in_valid", 64'(mul_in_valid), 64'd0);
                drain(0);

                // contention from reset
                do_reset();
                lat_cfg = 3;
                set_req(0, 32'd1000, 32'd7);
                set_req(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
                @(negedge clk);
                chk("cont_first_grant", 64'(req_ready), 64'b01);
                tick();
                req_valid[0] = 1'b0;
                @(negedge clk);
                chk("cont_busy_no_ready", 64'(req_ready), 64'b00);
                wait_rsp(0);
                chk("cont_second_grant", 64'(req_ready), 64'b10);
                tick();
                req_valid[1] = 1'b0;
                drain(0);
                drain(1);

                // backpressure
                lat_cfg = 1;
                set_req(0, 32'd12, 32'd12);
                wait_acc(0);
                set_req(0, 32'd9, 32'd9);
                wait_rsp(0);
                chk("bp_req0_blocked", 64'(req_ready[0]), 64'd0);
                chk("bp_no_issue", 64'(mul_in_valid), 64'd0);
                tick();
                set_req(1, 32'd6, 32'd7);
                @(negedge clk);
                chk("bp_req1_served", 64'(req_ready), 64'b10);
                tick();
                req_valid[1] = 1'b0;
                drain(1);
                chk("bp_slot0_held", 64'(rsp_valid[0]), 64'd1);
                chk("bp_req0_still_blocked", 64'(req_ready[0]), 64'd0);
                drain(0);
                wait_acc(0);
                drain(0);

                // zero operand, pulse on the first busy cycle
                lat_cfg = 0;
                set_req(0, 32'd0, 32'hFFFF_FFFF);
                wait_acc(0);
                @(negedge clk);
                chk("zero_busy", 64'(busy), 64'd1);
                @(negedge clk);
                chk("zero_idle", 64'(busy), 64'd0);
                chk("zero_rsp_valid", 64'(rsp_valid[0]), 64'd1);
                drain(0);

                // watchdog
                mul_auto = 1'b0;
                set_req(0, 32'd5, 32'd5);
                wait_acc(0);
                repeat (TMO - 1) @(posedge clk);
                #1;
                chk("wd_busy_before", 64'(busy), 64'd1);
                chk("wd_err_before", 64'(err), 64'd0);
                tick();
                chk("wd_err", 64'(err), 64'd1);
                chk("wd_busy", 64'(busy), 64'd0);
                exp_q[0].delete();
                inj_val = 64'hDEAD;
                #3;
                inj_cnt++;
                repeat (4) tick();
                chk("wd_late_pulse", 64'(rsp_valid), 64'd0);
                chk("wd_err_sticky", 64'(err), 64'd1);
                mul_auto = 1'b1;
                do_reset();

                // asynchronous reset in BUSY
                lat_cfg = 10;
                set_req(0, 32'd11, 32'd13);
                wait_acc(0);
                tick();
                tick();
                chk("ar_busy_before", 64'(busy), 64'd1);
                #2;
                resetn = 1'b0;
                #1;
                chk("ar_busy", 64'(busy), 64'd0);
                chk("ar_rsp_valid", 64'(rsp_valid), 64'd0);
                chk("ar_in_valid", 64'(mul_in_valid), 64'd0);
                for (int i = 0; i < NREQ; i++) exp_q[i].delete();
                tick();
                resetn = 1'b1;
                repeat (12) tick();
                chk("ar_late_pulse", 64'(rsp_valid), 64'd0);
                lat_cfg = 2;
                set_req(0, 32'd3, 32'd7);
                wait_acc(0);
                drain(0);

                // randomized traffic
                lat_rand = 1'b1;
                for (int c = 0; c < 600; c++) begin
                    @(negedge clk);
                    acc = req_valid & req_ready;
                    tick();
                    mul_in_ready = ($urandom_range(0, 3) != 0);
                    rsp_ready    = NREQ'($urandom);
                    for (int i = 0; i < NREQ; i++) begin
                        if (!req_valid[i] || acc[i]) begin
                            req_valid[i] = 1'b0;
                            if ($urandom_range(0, 1) == 1)
                                set_req(i, ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom, $urandom);
                        end
                    end
                end
                @(negedge clk);
                tick();
                req_valid    = '0;
                rsp_ready    = '1;
                mul_in_ready = 1'b1;
                repeat (30) tick();
                for (int i = 0; i < NREQ; i++)
                    chk($sformatf("rand_leftover%0d", i), 64'(exp_q[i].size()), 64'd0);
            end
            begin
                #1000000;
                checks++;
                errors++;
                $display("FAIL global_timeout: got no completion expected completion");
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
